// File: rtl/dma_stream_arbiter_if.sv
// Purpose: bundles the DMA-side request/write handshakes and the output stream of the arbiter.
// Latency: none; this is a signal grouping only.
// Backpressure: carries dma_write_ready per channel and out_ready from the downstream sink.
interface dma_stream_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 128,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]        dma_req;
    logic [NUM_CH-1:0]        dma_resp;
    logic [NUM_CH-1:0]        dma_write_valid;
    logic [NUM_CH*DATA_W-1:0] dma_write_data;
    logic [NUM_CH-1:0]        dma_write_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_sof;
    logic                     out_eof;
    logic                     out_ready;
    logic                     clr_err;
    logic                     err_timeout;
    logic                     err_len;
    logic                     busy;

    // Arbiter side.
    modport slave (
        input  dma_req, dma_write_valid, dma_write_data, out_ready, clr_err,
        output dma_resp, dma_write_ready, out_valid, out_data, out_ch,
               out_sof, out_eof, err_timeout, err_len, busy
    );

    // DMA channels plus downstream sink side.
    modport master (
        output dma_req, dma_write_valid, dma_write_data, out_ready, clr_err,
        input  dma_resp, dma_write_ready, out_valid, out_data, out_ch,
               out_sof, out_eof, err_timeout, err_len, busy
    );
endinterface

// File: rtl/dma_stream_arbiter.sv
// Purpose: round-robin arbiter forwarding one framed burst (header + payload) per grant onto a registered stream.
// Latency: grant pulse 1 cycle after req; each accepted word appears on the output 1 cycle after acceptance.
// Backpressure: input ready only while the output register can load; a stalled word is held stable.
module dma_stream_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 256,
    parameter int TIMEOUT   = 1024,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input logic               fpu_clk,
    input logic               reset,
    dma_stream_arbiter_if.slave bus
);
    localparam int LEN_W  = 16;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [NUM_CH-1:0]   resp_q, resp_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic                err_to_q, err_to_d;
    logic                err_len_q, err_len_d;

    logic                load_ok, xfer_rdy, beat_vld, accept;
    logic [DATA_W-1:0]   beat_dat;
    logic [7:0]          opcode;
    logic [LEN_W-1:0]    hdr_len;
    logic                pick_vld;
    logic [CH_W-1:0]     pick;
    logic                set_to, set_len;

    // Granted-channel mux, output-register load condition and round-robin search.
    always_comb begin
        load_ok  = !out_valid_q || bus.out_ready;
        xfer_rdy = (state_q != S_IDLE) && load_ok;
        beat_vld = 1'b0;
        beat_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_q == CH_W'(k)) begin
                beat_vld = bus.dma_write_valid[k];
                beat_dat = bus.dma_write_data[k*DATA_W +: DATA_W];
            end
        end
        accept  = xfer_rdy && beat_vld;
        opcode  = beat_dat[79:72];
        hdr_len = beat_dat[71:56];
        // Channels above last grant first, then wrap around to the lower ones.
        pick_vld = 1'b0;
        pick     = last_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && bus.dma_req[k] && (CH_W'(k) > last_q)) begin
                pick_vld = 1'b1;
                pick     = CH_W'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && bus.dma_req[k] && (CH_W'(k) <= last_q)) begin
                pick_vld = 1'b1;
                pick     = CH_W'(k);
            end
        end
    end

    // Next-state: arbitration, burst framing, idle timeout and sticky errors.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        resp_d      = '0;
        rem_d       = rem_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        set_to      = 1'b0;
        set_len     = 1'b0;

        if (load_ok) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_data_d = beat_dat;
            out_ch_d   = grant_q;
            sof_d      = (state_q == S_HEADER);
            eof_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (pick_vld) begin
                    grant_d = pick;
                    last_d  = pick;
                    resp_d  = NUM_CH'(1) << pick;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (int'(hdr_len) > MAX_BURST) begin
                        set_len = 1'b1;
                    end
                    if ((opcode == 8'h01) || (hdr_len == '0)) begin
                        eof_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = hdr_len;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && (rem_q != '0)) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        eof_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle counting only while the granted channel is offered a slot and leaves it empty.
        if (state_q != S_IDLE) begin
            if (accept || !load_ok) begin
                idle_d = '0;
            end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                idle_d  = '0;
                set_to  = 1'b1;
                state_d = S_IDLE;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        err_to_d  = (err_to_q && !bus.clr_err) || set_to;
        err_len_d = (err_len_q && !bus.clr_err) || set_len;
    end

    // State and output registers; reset drops any burst in flight.
    always_ff @(posedge fpu_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            resp_q      <= '0;
            rem_q       <= '0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_to_q    <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            resp_q      <= resp_d;
            rem_q       <= rem_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_to_q    <= err_to_d;
            err_len_q   <= err_len_d;
        end
    end

    assign bus.dma_resp        = resp_q;
    assign bus.dma_write_ready = xfer_rdy ? (NUM_CH'(1) << grant_q) : '0;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_ch          = out_ch_q;
    assign bus.out_sof         = sof_q;
    assign bus.out_eof         = eof_q;
    assign bus.err_timeout     = err_to_q;
    assign bus.err_len         = err_len_q;
    assign bus.busy            = (state_q != S_IDLE);
endmodule

// File: doc/dma_stream_arbiter.md
Name: dma_stream_arbiter

Overview:
- Parametrised N-channel successor to the fixed four-channel (a..d) TSN-DMA write front end.
- Arbitrates the NUM_CH per-channel req/resp handshakes round-robin, then forwards one framed burst (header word plus payload words) from the granted channel onto a single registered output stream toward the DPRAM write path.
- Adds burst framing (sof/eof, channel id), header-only opcode handling, stall-aware timeout recovery and sticky error flags.

Parameters:
- NUM_CH, 4, number of DMA channels (2..16).
- DATA_W, 128, word width; must be >= 80.
- MAX_BURST, 256, largest legal payload length in words.
- TIMEOUT, 1024, idle cycles allowed inside a burst before abort.
- CH_W, $clog2(NUM_CH), channel id width (derived).

Ports:
- fpu_clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dma_req  in  NUM_CH  per-channel burst request.
- dma_resp  out  NUM_CH  one-cycle grant pulse.
- dma_write_valid  in  NUM_CH  per-channel word valid.
- dma_write_data  in  NUM_CH*DATA_W  per-channel word; channel k occupies [k*DATA_W +: DATA_W].
- dma_write_ready  out  NUM_CH  per-channel ready.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  output word.
- out_ch  out  CH_W  source channel of the output word.
- out_sof  out  1  word is a header.
- out_eof  out  1  word is the last of its burst.
- out_ready  in  1  downstream ready.
- clr_err  in  1  clears the sticky error flags.
- err_timeout  out  1  sticky; set on burst abort.
- err_len  out  1  sticky; set when header length > MAX_BURST.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_grant = NUM_CH-1, so channel 0 wins first.
  - Counters 0.
- Header fields:
  - opcode = data[79:72].
  - length = data[71:56].
  - Bits [15:0] (dpram addr) pass through unmodified.
- Output stage:
  - Single register.
  - Load allowed when (out_valid==0 || out_ready==1).
  - Words are held stable while out_valid && !out_ready.
- dma_write_ready[k] = (state in HEADER/PAYLOAD) && k==g && load allowed. Combinational; 0 for all non-granted channels.
- A beat is accepted when dma_write_valid[g] && dma_write_ready[g]. The output register loads on the next edge with out_ch=g and sof/eof per state.
- IDLE:
  - If any dma_req is set, pick the first requester searching last_grant+1, +2, ... modulo NUM_CH.
  - Register g, set last_grant=g, drive dma_resp[g]=1 for exactly one cycle (the cycle after req is seen), go to HEADER.
  - Requests arriving during a burst wait; req need not be held after resp.
- HEADER:
  - Accept one word with out_sof=1.
  - If opcode==8'h01 or length==0: out_eof=1, go to IDLE.
  - Otherwise remaining=length, go to PAYLOAD.
  - If length>MAX_BURST, set err_len; the burst is still forwarded in full.
- PAYLOAD:
  - Each accept decrements remaining.
  - The word accepted when remaining==1 carries out_eof=1; state then returns to IDLE.
- Back-to-back: IDLE is entered on the eof accept edge. The next grant's dma_resp occurs one cycle later, giving a minimum 2-cycle gap between bursts on the input side.
- Timeout:
  - In HEADER/PAYLOAD, idle_cnt increments each cycle with dma_write_ready[g]=1 and dma_write_valid[g]=0.
  - idle_cnt clears on accept and while downstream stalls.
  - When idle_cnt reaches TIMEOUT-1: set err_timeout, go to IDLE.
  - No synthetic eof is emitted. The downstream detects truncation via err_timeout.
- Errors:
  - err_* are sticky until clr_err=1.
  - Clearing takes effect the next edge.
  - A set event in the same cycle as clr_err wins (flag stays 1).
- remaining is LEN_W=16 bits wide; it never wraps because it is only decremented while nonzero.
- Reset mid-burst: the burst is dropped immediately, out_valid returns to 0, and no recovery is attempted.

Test Plan:
1. Single channel: ch0 req, header opcode 8'h03, length=16, 16 payload words {i,i,i,i}, out_ready=1 -> dma_resp[0] pulses 1 cycle after req. 17 output words: first has sof=1, 17th has eof=1, out_ch=0, data in order.
2. All four channels request simultaneously, each length=4, out_ready=1 -> grants issued in order 0,1,2,3. A second round of 1 and 3 requesting -> order 1,3. No interleaving within any burst.
3. Header-only: ch1 sends opcode 8'h01 with length=16 -> exactly one output word with sof=1 and eof=1, state back in IDLE; a following ch2 request is granted.
4. Backpressure: out_ready toggles 1,0,0,1 repeatedly during a length=8 burst -> out_data is stable while stalled, all 9 words are delivered exactly once, no timeout.
5. Timeout with TIMEOUT=16: ch3 is granted, sends header (length=8) and 2 payload words, then stops -> err_timeout=1 after 16 idle cycles, busy=0. A pending ch0 request is then served. clr_err clears the flag.
6. Length error and reset: header length=300 -> err_len=1 and all 300 words are forwarded. Assert reset mid-burst -> all outputs 0 asynchronously; after release, ch0 is granted first.
